crc_byte_feeder: RTL and testbench
==================================

Name: crc_byte_feeder

Overview:
Upstream feeder for the byte-parallel CRC-16 engine.
- Accepts a framed 32-bit word stream with a valid/ready handshake.
- Serialises each word into one byte per cycle on the engine's data/data_valid inputs, and marks the first and last byte of each frame.
- After the last byte, waits a fixed engine latency, then captures the engine's crc result into a frame-result register with a one-cycle valid pulse.

Parameters:
WORD_BYTES, 4, bytes per input word (2..8).
MSB_FIRST, 0, 0 = byte 0 (bits 7:0) sent first; 1 = top byte sent first.
CRC_LAT, 2, cycles from last-byte cycle to crc_in being final (1..15).

Ports:
clk  input  1  clock; all state changes on rising edge.
rst  input  1  reset, asynchronous, active-high.
in_valid  input  1  upstream word valid.
in_ready  output  1  feeder can accept a word this cycle.
in_data  input  8*WORD_BYTES  word payload.
in_last  input  1  word is the final word of its frame.
in_nbytes  input  clog2(WORD_BYTES)+1  valid byte count of a last word; 0 or >WORD_BYTES means WORD_BYTES; ignored when in_last=0.
data  output  8  byte to the CRC engine.
data_valid  output  1  data is valid this cycle.
frame_start  output  1  high with the first byte of a frame.
frame_end  output  1  high with the last byte of a frame.
crc_in  input  16  crc output of the CRC engine.
crc_out  output  16  captured frame CRC.
crc_out_valid  output  1  one-cycle pulse when crc_out is updated.
busy  output  1  state != IDLE.

Behaviour:
- Reset values: data, data_valid, frame_start, frame_end, crc_out, crc_out_valid, busy = 0; state = IDLE. Reset mid-frame discards the partial frame, and no crc_out_valid pulse is issued for it.
- All outputs except in_ready are registered. in_ready is combinational from state and counters only, never from in_valid.
- Accept occurs at a rising edge where in_valid && in_ready. The word loads into a shift register with byte count cnt and a last flag.
- States and in_ready:
  - IDLE: in_ready=1. On accept, go to SEND and assert frame_start with the first byte.
  - SEND: one byte per cycle, data_valid=1. in_ready=1 only in the cycle presenting the final byte of a non-last word.
    - Accept in that cycle: the next word's first byte follows in the next cycle with no bubble.
    - No accept: go to NEXT.
    - Final byte of a last word: frame_end=1 with that byte, then go to CRCWAIT.
  - NEXT: in_ready=1, data_valid=0, frame stays open. On accept, go to SEND (frame_start stays 0).
  - CRCWAIT: in_ready=0, data_valid=0.
- Latency: word accepted at edge E gives its first byte in the cycle after E. Bytes follow in consecutive cycles in MSB_FIRST order.
- Partial last word: only the first in_nbytes bytes are sent, in send order; the remaining bytes are dropped.
- Single-byte frame (first word is last, nbytes=1): frame_start and frame_end are both high in the same cycle.
- CRC capture: with the final byte in cycle C, crc_in is sampled at the end of cycle C+CRC_LAT. crc_out updates and crc_out_valid=1 in cycle C+CRC_LAT+1, and state returns to IDLE in that same cycle. A new word can be accepted in that cycle.
- in_data is ignored when in_valid=0. in_valid dropping mid-frame only creates NEXT gaps. No timeout exists.
- crc_out holds its value until the next capture.

Test Plan:
- Reset, then one word 0x44332211 with last=1, nbytes=4, MSB_FIRST=0 -> data 11,22,33,44 on 4 consecutive cycles. frame_start on 11, frame_end on 44. Bench drives crc_in=0xBEEF at cycle C+2 -> crc_out=0xBEEF, crc_out_valid pulses 1 cycle at C+3.
- Two-word frame, in_valid held high: 0x04030201 (last=0), then 0x08070605 (last=1) -> 8 bytes 01..08 with no bubble. Exactly one frame_start and one frame_end, and in_ready high only during byte 04.
- Same frame with in_valid low for 3 cycles between the words -> data_valid low for 3 cycles after byte 04. No frame_start on byte 05.
- Last word 0xDDCCBBAA with nbytes=1, MSB_FIRST=0 -> single byte AA with frame_start=frame_end=1. Repeat with nbytes=3, MSB_FIRST=1 -> DD,CC,BB.
- Back-to-back frames -> second frame accepted in the crc_out_valid cycle. in_ready=0 throughout CRCWAIT, and crc_out changes only on the pulse.
- Assert rst during byte 2 of a 4-byte frame -> all outputs 0 asynchronously. No crc_out_valid pulse, and the next frame starts cleanly from IDLE.

Source files
------------

// File: rtl/crc_byte_feeder.sv
// rtl/crc_byte_feeder.sv - word-to-byte serialiser and frame CRC capture for the CRC-16 engine
module crc_byte_feeder #(
  parameter int WORD_BYTES = 4,
  parameter bit MSB_FIRST  = 1'b0,
  parameter int CRC_LAT    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [8*WORD_BYTES-1:0]       in_data,
  input  logic                          in_last,
  input  logic [$clog2(WORD_BYTES):0]   in_nbytes,
  output logic [7:0]                    data,
  output logic                          data_valid,
  output logic                          frame_start,
  output logic                          frame_end,
  input  logic [15:0]                   crc_in,
  output logic [15:0]                   crc_out,
  output logic                          crc_out_valid,
  output logic                          busy
);

  localparam int W   = 8 * WORD_BYTES;
  localparam int NBW = $clog2(WORD_BYTES) + 1;

  typedef enum logic [1:0] {IDLE, SEND, NEXT, CRCWAIT} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     sr_q, sr_d;
  logic [NBW-1:0]   cnt_q, cnt_d;
  logic             last_q, last_d;
  logic [3:0]       wait_q, wait_d;
  logic [7:0]       data_q, data_d;
  logic             dv_q, dv_d;
  logic             fs_q, fs_d;
  logic             fe_q, fe_d;
  logic [15:0]      crc_q, crc_d;
  logic             cv_q, cv_d;
  logic             busy_q, busy_d;

  logic             accept;
  logic [NBW-1:0]   eff_n;
  logic [7:0]       first_byte;
  logic [W-1:0]     sr_load;
  logic [7:0]       next_byte;
  logic [W-1:0]     sr_shift;

  // cnt_q counts bytes still held in sr_q behind the byte currently on data;
  // the word boundary is therefore the cycle where cnt_q reaches zero
  assign in_ready = (state_q == IDLE) || (state_q == NEXT) ||
                    ((state_q == SEND) && (cnt_q == '0) && !last_q);
  assign accept   = in_valid && in_ready;

  // byte selection for a freshly loaded word and for the held remainder
  always_comb begin
    eff_n = NBW'(WORD_BYTES);
    if (in_last && (in_nbytes != '0) && (in_nbytes <= NBW'(WORD_BYTES)))
      eff_n = in_nbytes;
    first_byte = MSB_FIRST ? in_data[W-1 -: 8] : in_data[7:0];
    sr_load    = MSB_FIRST ? (in_data << 8) : (in_data >> 8);
    next_byte  = MSB_FIRST ? sr_q[W-1 -: 8] : sr_q[7:0];
    sr_shift   = MSB_FIRST ? (sr_q << 8) : (sr_q >> 8);
  end

  // next-state and registered-output computation
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    wait_d  = wait_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    fs_d    = 1'b0;
    fe_d    = 1'b0;
    crc_d   = crc_q;
    cv_d    = 1'b0;

    case (state_q)
      SEND: begin
        if (cnt_q != '0) begin
          data_d = next_byte;
          sr_d   = sr_shift;
          cnt_d  = cnt_q - NBW'(1);
          dv_d   = 1'b1;
          fe_d   = last_q && (cnt_q == NBW'(1));
        end else if (last_q) begin
          state_d = CRCWAIT;
          wait_d  = 4'(CRC_LAT - 1);
        end else if (!accept) begin
          state_d = NEXT;
        end
      end
      CRCWAIT: begin
        if (wait_q == 4'd0) begin
          crc_d   = crc_in;
          cv_d    = 1'b1;
          state_d = IDLE;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      default: ;
    endcase

    // a new word always starts presenting its first byte on the following cycle
    if (accept) begin
      state_d = SEND;
      data_d  = first_byte;
      sr_d    = sr_load;
      cnt_d   = eff_n - NBW'(1);
      last_d  = in_last;
      dv_d    = 1'b1;
      fs_d    = (state_q == IDLE);
      fe_d    = in_last && (eff_n == NBW'(1));
    end

    busy_d = (state_d != IDLE);
  end

  // state and output registers; reset drops any partial frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      wait_q  <= 4'd0;
      data_q  <= 8'd0;
      dv_q    <= 1'b0;
      fs_q    <= 1'b0;
      fe_q    <= 1'b0;
      crc_q   <= 16'd0;
      cv_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      wait_q  <= wait_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      fs_q    <= fs_d;
      fe_q    <= fe_d;
      crc_q   <= crc_d;
      cv_q    <= cv_d;
      busy_q  <= busy_d;
    end
  end

  assign data          = data_q;
  assign data_valid    = dv_q;
  assign frame_start   = fs_q;
  assign frame_end     = fe_q;
  assign crc_out       = crc_q;
  assign crc_out_valid = cv_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_crc_byte_feeder.sv
// tb/tb_crc_byte_feeder.sv - scoreboard bench for crc_byte_feeder, LSB-first and MSB-first instances
module tb_crc_byte_feeder;

  localparam int WB  = 4;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic [2:0]  in_nbytes;
  logic [15:0] crc_in;

  logic        rdy0, dv0, fs0, fe0, cv0, bz0;
  logic        rdy1, dv1, fs1, fe1, cv1, bz1;
  logic [7:0]  d0, d1;
  logic [15:0] co0, co1;

  crc_byte_feeder #(.WORD_BYTES(WB), .MSB_FIRST(1'b0), .CRC_LAT(LAT)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
    .in_last(in_last), .in_nbytes(in_nbytes), .data(d0), .data_valid(dv0),
    .frame_start(fs0), .frame_end(fe0), .crc_in(crc_in), .crc_out(co0),
    .crc_out_valid(cv0), .busy(bz0));

  crc_byte_feeder #(.WORD_BYTES(WB), .MSB_FIRST(1'b1), .CRC_LAT(LAT)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
    .in_last(in_last), .in_nbytes(in_nbytes), .data(d1), .data_valid(dv1),
    .frame_start(fs1), .frame_end(fe1), .crc_in(crc_in), .crc_out(co1),
    .crc_out_valid(cv1), .busy(bz1));

  always #5 clk = ~clk;

  // expected byte entry: {gap[3:0], start, end, byte[7:0]}
  logic [13:0] q0[$];
  logic [13:0] q1[$];
  logic [15:0] crc_q[$];
  int          checks = 0;
  int          errors = 0;
  int          since_end = -1;
  int          idle_cnt = 0;
  logic [15:0] last_crc = 16'd0;
  logic [13:0] e0, e1;
  logic [15:0] ecrc;
  logic        ev;
  int          w;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_word(input logic [31:0] wd, input logic last, input logic [2:0] nb,
                           input logic first, input int gap);
    int n;
    logic s, e;
    logic [3:0] g;
    if (last && nb != 3'd0 && int'(nb) <= WB) n = int'(nb);
    else n = WB;
    for (int i = 0; i < n; i++) begin
      s = first && (i == 0);
      e = last && (i == n - 1);
      g = (i == 0 && !first) ? 4'(gap) : 4'd0;
      q0.push_back({g, s, e, wd[8*i +: 8]});
      q1.push_back({g, s, e, wd[8*(WB-1-i) +: 8]});
    end
  endtask

  // drive one word and hold it until accepted; waited = cycles in_ready was low
  task automatic send_word(input logic [31:0] wd, input logic last, input logic [2:0] nb,
                           input logic first, input int gap, input logic [15:0] crc,
                           output int waited);
    in_data   = wd;
    in_last   = last;
    in_nbytes = nb;
    in_valid  = 1'b1;
    waited    = 0;
    @(negedge clk);
    while (!rdy0 && waited < 60) begin
      waited++;
      @(negedge clk);
    end
    if (!rdy0) chk("accept_timeout", 32'(rdy0), 32'd1);
    push_word(wd, last, nb, first, gap);
    if (last) crc_q.push_back(crc);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_data   = $urandom;
    in_last   = 1'($urandom);
    in_nbytes = 3'($urandom);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || crc_q.size() != 0) && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({tag, "_drain"}, 32'(q0.size() + q1.size() + crc_q.size()), 32'd0);
    @(posedge clk);
    #1;
    chk({tag, "_idle_busy"}, 32'(bz0), 32'd0);
    chk({tag, "_idle_ready"}, 32'(rdy0), 32'd1);
  endtask

  // scoreboard: bytes, flags, gaps, crc timing and crc hold
  always @(negedge clk) begin
    if (!rst) begin
      if (since_end >= 0) since_end++;
      if (dv0) begin
        if (q0.size() == 0) chk("unexpected_byte0", 32'(d0), 32'hFFFF_FFFF);
        else begin
          e0 = q0.pop_front();
          chk("data0", 32'(d0), 32'(e0[7:0]));
          chk("start0", 32'(fs0), 32'(e0[9]));
          chk("end0", 32'(fe0), 32'(e0[8]));
          if (!e0[9]) chk("gap0", 32'(idle_cnt), 32'(e0[13:10]));
        end
      end
      if (dv1) begin
        if (q1.size() == 0) chk("unexpected_byte1", 32'(d1), 32'hFFFF_FFFF);
        else begin
          e1 = q1.pop_front();
          chk("data1", 32'(d1), 32'(e1[7:0]));
          chk("start1", 32'(fs1), 32'(e1[9]));
          chk("end1", 32'(fe1), 32'(e1[8]));
        end
      end
      if (dv0) idle_cnt = 0;
      else idle_cnt++;
      if (dv0 && fe0) since_end = 0;

      ev = (since_end == LAT + 1);
      chk("crc_valid0", 32'(cv0), 32'(ev));
      chk("crc_valid1", 32'(cv1), 32'(ev));
      if (ev) begin
        if (crc_q.size() == 0) chk("crc_missing", 32'd0, 32'd1);
        else begin
          ecrc = crc_q.pop_front();
          chk("crc_out0", 32'(co0), 32'(ecrc));
          chk("crc_out1", 32'(co1), 32'(ecrc));
          last_crc = ecrc;
        end
        since_end = -1;
      end else begin
        chk("crc_hold0", 32'(co0), 32'(last_crc));
        chk("crc_hold1", 32'(co1), 32'(last_crc));
      end

      if (since_end == LAT && crc_q.size() != 0) crc_in = crc_q[0];
      else crc_in = 16'($urandom);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    in_last   = 1'b0;
    in_nbytes = 3'd0;
    crc_in    = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs0", 32'({d0, dv0, fs0, fe0, co0, cv0, bz0}), 32'd0);
    chk("reset_outs1", 32'({d1, dv1, fs1, fe1, co1, cv1, bz1}), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_ready", 32'(rdy0), 32'd1);

    // single full word frame
    send_word(32'h44332211, 1'b1, 3'd4, 1'b1, 0, 16'hBEEF, w);
    chk("t1_wait", 32'(w), 32'd0);
    wait_drain("t1");

    // two-word frame, no bubble
    send_word(32'h04030201, 1'b0, 3'd4, 1'b1, 0, 16'h0000, w);
    send_word(32'h08070605, 1'b1, 3'd4, 1'b0, 0, 16'hC0DE, w);
    chk("t2_ready_at_byte4", 32'(w), 32'd3);
    wait_drain("t2");

    // two-word frame with a 3-cycle gap
    send_word(32'h04030201, 1'b0, 3'd4, 1'b1, 0, 16'h0000, w);
    repeat (6) @(posedge clk);
    #1;
    chk("t3_busy_next", 32'({bz0, dv0, rdy0}), 32'b101);
    send_word(32'h08070605, 1'b1, 3'd4, 1'b0, 3, 16'h1357, w);
    chk("t3_wait", 32'(w), 32'd0);
    wait_drain("t3");

    // partial last words
    send_word(32'hDDCCBBAA, 1'b1, 3'd1, 1'b1, 0, 16'hAAAA, w);
    wait_drain("t4a");
    send_word(32'hDDCCBBAA, 1'b1, 3'd3, 1'b1, 0, 16'h5555, w);
    wait_drain("t4b");

    // nbytes ignored when not last; 0 and >WORD_BYTES mean a full word
    send_word(32'h11223344, 1'b0, 3'd1, 1'b1, 0, 16'h0000, w);
    send_word(32'h55667788, 1'b1, 3'd0, 1'b0, 0, 16'h0F0F, w);
    wait_drain("t5a");
    send_word(32'h99AABBCC, 1'b1, 3'd5, 1'b1, 0, 16'hF0F0, w);
    wait_drain("t5b");

    // back-to-back frames: second accepted in the crc_out_valid cycle
    send_word(32'hCAFEF00D, 1'b1, 3'd4, 1'b1, 0, 16'h2222, w);
    send_word(32'h12345678, 1'b1, 3'd2, 1'b1, 0, 16'h3333, w);
    chk("t6_wait_crcwait", 32'(w), 32'(WB + LAT));
    wait_drain("t6");

    // asynchronous reset during byte 2
    send_word(32'hA1B2C3D4, 1'b1, 3'd4, 1'b1, 0, 16'h1234, w);
    @(posedge clk);
    #1;
    chk("t7_mid_frame", 32'(dv0), 32'd1);
    rst = 1'b1;
    #1;
    chk("t7_rst_outs0", 32'({d0, dv0, fs0, fe0, co0, cv0, bz0}), 32'd0);
    chk("t7_rst_outs1", 32'({d1, dv1, fs1, fe1, co1, cv1, bz1}), 32'd0);
    q0.delete();
    q1.delete();
    crc_q.delete();
    since_end = -1;
    idle_cnt  = 0;
    last_crc  = 16'd0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("t7_after_rst_ready", 32'({rdy0, bz0}), 32'b10);
    repeat (8) @(posedge clk);
    #1;
    send_word(32'h01020304, 1'b1, 3'd2, 1'b1, 0, 16'h4444, w);
    chk("t7_restart_wait", 32'(w), 32'd0);
    wait_drain("t7");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
